// File: rtl/pat_align_pkg.sv
// Shared types and the X-aware compare rule for the pattern alignment checker.
package pat_align_pkg;

    localparam int LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CHECK,
        DONE
    } state_e;

    // A golden bit that is X/Z is don't-care; a known golden bit must be matched exactly.
    function automatic logic bit_mismatch(input logic gold_bit, input logic dut_bit);
        return !$isunknown(gold_bit) && (dut_bit !== gold_bit);
    endfunction

endpackage

// File: rtl/pat_delay_line.sv
// Golden-stream delay line: LATENCY-deep shift register with push enable and a full flag.
module pat_delay_line
    import pat_align_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    localparam int FILL_W = $clog2(LATENCY_MAX + 1);

    generate
        if (LATENCY == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = ^{clk, rst, push};
            assign dout = din;
            assign full = 1'b1;
        end else begin : g_shift
            localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LATENCY);

            logic [WIDTH-1:0]  line_q [LATENCY];
            logic [WIDTH-1:0]  line_d [LATENCY];
            logic [FILL_W-1:0] fill_q;
            logic [FILL_W-1:0] fill_d;

            always_comb begin
                line_d = line_q;
                fill_d = fill_q;
                if (push) begin
                    line_d[0] = din;
                    for (int i = 1; i < LATENCY; i++) begin
                        line_d[i] = line_q[i-1];
                    end
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        line_q[i] <= '0;
                    end
                    fill_q <= '0;
                end else begin
                    line_q <= line_d;
                    fill_q <= fill_d;
                end
            end

            // Oldest entry sits at the far end of the line.
            assign dout = line_q[LATENCY-1];
            assign full = (fill_q == FILL_FULL);
        end
    endgenerate

endmodule

// File: rtl/pat_align_checker.sv
// Aligns a golden stream to a DUT stream, presents the checked pair and keeps mismatch statistics.
//   state | meaning
//   IDLE  | after reset; first valid sample starts filling (or is checked when LATENCY=0)
//   FILL  | delay line filling; DUT samples discarded
//   CHECK | every valid sample is compared against the oldest golden sample
//   DONE  | RUN_CYCLES checks recorded; inputs ignored, outputs hold
module pat_align_checker
    import pat_align_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LATENCY    = 2,
    parameter int RUN_CYCLES = 1024,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] dut_q,
    input  logic [WIDTH-1:0] gold_d,
    output logic             chk_valid,
    output logic [WIDTH-1:0] aligned_test,
    output logic [WIDTH-1:0] aligned_pat,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err,
    output logic [CNT_W-1:0] chk_cnt,
    output logic             done,
    output logic             pass
);

    localparam logic [CNT_W-1:0] LAST_CHK = CNT_W'(RUN_CYCLES - 1);
    localparam logic             NO_FILL  = (LATENCY == 0);

    state_e           state_q, state_d;
    logic             push, do_check, line_full, miss;
    logic [WIDTH-1:0] gold_aligned;
    logic [WIDTH-1:0] miss_bits;

    logic             chk_valid_q, chk_valid_d;
    logic             mismatch_q, mismatch_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] aligned_test_q, aligned_test_d;
    logic [WIDTH-1:0] aligned_pat_q, aligned_pat_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] first_err_q, first_err_d;
    logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;

    pat_delay_line #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY)
    ) u_delay_line (
        .clk (clk),
        .rst (rst),
        .push(push),
        .din (gold_d),
        .dout(gold_aligned),
        .full(line_full)
    );

    always_comb begin
        miss_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            miss_bits[i] = bit_mismatch(gold_aligned[i], dut_q[i]);
        end
        miss = |miss_bits;
    end

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        do_check = 1'b0;
        case (state_q)
            IDLE: if (en) begin
                push     = 1'b1;
                do_check = NO_FILL;
                state_d  = NO_FILL ? CHECK : FILL;
            end
            FILL: if (en) begin
                push     = 1'b1;
                do_check = line_full;
                if (line_full) state_d = CHECK;
            end
            CHECK: if (en) begin
                push     = 1'b1;
                do_check = 1'b1;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (do_check && (chk_cnt_q == LAST_CHK)) state_d = DONE;
    end

    always_comb begin
        chk_valid_d    = do_check;
        mismatch_d     = do_check && miss;
        aligned_test_d = do_check ? dut_q : aligned_test_q;
        aligned_pat_d  = do_check ? gold_aligned : aligned_pat_q;
        chk_cnt_d      = do_check ? chk_cnt_q + CNT_W'(1) : chk_cnt_q;
        err_cnt_d      = err_cnt_q;
        first_err_d    = first_err_q;
        done_d         = done_q || (do_check && (chk_cnt_q == LAST_CHK));
        if (mismatch_d) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            // err_cnt saturates rather than wrapping, so zero always means no earlier error.
            if (err_cnt_q == '0) first_err_d = chk_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            chk_valid_q    <= 1'b0;
            mismatch_q     <= 1'b0;
            done_q         <= 1'b0;
            aligned_test_q <= '0;
            aligned_pat_q  <= '0;
            err_cnt_q      <= '0;
            first_err_q    <= '1;
            chk_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            chk_valid_q    <= chk_valid_d;
            mismatch_q     <= mismatch_d;
            done_q         <= done_d;
            aligned_test_q <= aligned_test_d;
            aligned_pat_q  <= aligned_pat_d;
            err_cnt_q      <= err_cnt_d;
            first_err_q    <= first_err_d;
            chk_cnt_q      <= chk_cnt_d;
        end
    end

    assign chk_valid    = chk_valid_q;
    assign mismatch     = mismatch_q;
    assign done         = done_q;
    assign aligned_test = aligned_test_q;
    assign aligned_pat  = aligned_pat_q;
    assign err_cnt      = err_cnt_q;
    assign first_err    = first_err_q;
    assign chk_cnt      = chk_cnt_q;
    assign pass         = done_q && (err_cnt_q == '0);

endmodule

// File: tb/tb_pat_align_checker.sv
// Directed bench: one checker with LATENCY=2/RUN_CYCLES=8 and one with LATENCY=0/RUN_CYCLES=4.
module tb_pat_align_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_en;
    logic [7:0]  a_dut, a_gold, a_test, a_pat;
    logic        a_chk_valid, a_mismatch, a_done, a_pass;
    logic [15:0] a_err_cnt, a_first_err, a_chk_cnt;

    logic        z_rst, z_en;
    logic [7:0]  z_dut, z_gold, z_test, z_pat;
    logic        z_chk_valid, z_mismatch, z_done, z_pass;
    logic [15:0] z_err_cnt, z_first_err, z_chk_cnt;

    pat_align_checker #(.WIDTH(8), .LATENCY(2), .RUN_CYCLES(8), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .dut_q(a_dut), .gold_d(a_gold),
        .chk_valid(a_chk_valid), .aligned_test(a_test), .aligned_pat(a_pat),
        .mismatch(a_mismatch), .err_cnt(a_err_cnt), .first_err(a_first_err),
        .chk_cnt(a_chk_cnt), .done(a_done), .pass(a_pass)
    );

    pat_align_checker #(.WIDTH(8), .LATENCY(0), .RUN_CYCLES(4), .CNT_W(16)) u_dut_z (
        .clk(clk), .rst(z_rst), .en(z_en), .dut_q(z_dut), .gold_d(z_gold),
        .chk_valid(z_chk_valid), .aligned_test(z_test), .aligned_pat(z_pat),
        .mismatch(z_mismatch), .err_cnt(z_err_cnt), .first_err(z_first_err),
        .chk_cnt(z_chk_cnt), .done(z_done), .pass(z_pass)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_rst = 1'b1; a_en = 1'b0; a_gold = 8'h00; a_dut = 8'h00;
        tick();
        a_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] xprobe;
        logic [3:0] rhi;
        logic       four_state, zbit;
        int         mpulses, v, exp_cnt;
        logic       exp_valid;

        z_rst = 1'b1; z_en = 1'b0; z_gold = 8'h00; z_dut = 8'h00;
        reset_a();
        z_rst = 1'b0;

        // reset state
        check_val("rst_valid", a_chk_valid, 0);
        check_val("rst_mismatch", a_mismatch, 0);
        check_val("rst_test", a_test, 0);
        check_val("rst_pat", a_pat, 0);
        check_val("rst_err", a_err_cnt, 0);
        check_val("rst_first", a_first_err, 16'hFFFF);
        check_val("rst_chk", a_chk_cnt, 0);
        check_val("rst_done", a_done, 0);
        check_val("rst_pass", a_pass, 0);

        // clean run
        for (int k = 0; k < 10; k++) begin
            a_en = 1'b1; a_gold = 8'(8'h10 + k);
            a_dut = (k >= 2) ? 8'(8'h10 + k - 2) : 8'h00;
            tick();
            if (k == 1) check_val("t1_fill_valid", a_chk_valid, 0);
            if (k == 2) begin
                check_val("t1_first_valid", a_chk_valid, 1);
                check_val("t1_first_test", a_test, 8'h10);
                check_val("t1_first_pat", a_pat, 8'h10);
            end
            if (k == 8) check_val("t1_done_early", a_done, 0);
        end
        check_val("t1_done", a_done, 1);
        check_val("t1_pass", a_pass, 1);
        check_val("t1_err", a_err_cnt, 0);
        check_val("t1_first", a_first_err, 16'hFFFF);
        check_val("t1_chk", a_chk_cnt, 8);
        a_en = 1'b1; a_gold = 8'h55; a_dut = 8'hAA;
        tick();
        check_val("t1_post_valid", a_chk_valid, 0);
        check_val("t1_post_chk", a_chk_cnt, 8);
        check_val("t1_post_pat", a_pat, 8'h17);

        // corrupted checks 3 and 5
        reset_a();
        mpulses = 0;
        for (int k = 0; k < 10; k++) begin
            a_en = 1'b1; a_gold = 8'(8'h10 + k);
            a_dut = (k >= 2) ? 8'(8'h10 + k - 2) : 8'h00;
            if (k == 5 || k == 7) a_dut = 8'hFF;
            tick();
            if (a_mismatch === 1'b1) mpulses++;
        end
        check_val("t2_pulses", mpulses, 2);
        check_val("t2_err", a_err_cnt, 2);
        check_val("t2_first", a_first_err, 3);
        check_val("t2_done", a_done, 1);
        check_val("t2_pass", a_pass, 0);

        // en toggling through FILL and CHECK
        reset_a();
        v = 0; exp_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            a_en = (c % 2 == 0);
            if (a_en) begin
                a_gold = 8'(8'h20 + v);
                a_dut = (v >= 2) ? 8'(8'h20 + v - 2) : 8'h00;
                exp_valid = (v >= 2);
                v++;
            end else begin
                a_gold = 8'hEE; a_dut = 8'hDD; exp_valid = 1'b0;
            end
            tick();
            check_val("t3_valid", a_chk_valid, exp_valid);
            if (exp_valid) exp_cnt++;
        end
        check_val("t3_chk", a_chk_cnt, exp_cnt);
        check_val("t3_err", a_err_cnt, 0);

        // golden high nibble unknown, then a Z DUT bit against golden 0
        xprobe = 8'bxxxx_xxxx;
        four_state = $isunknown(xprobe);
        if (four_state) zbit = 1'bz;
        else            zbit = 1'b1;
        reset_a();
        for (int k = 0; k < 8; k++) begin
            rhi = four_state ? 4'($urandom_range(15)) : xprobe[7:4];
            a_en = 1'b1;
            a_gold = (k < 6) ? {xprobe[7:4], 4'(k)} : 8'h00;
            a_dut = (k >= 2) ? {rhi, 4'(k - 2)} : 8'h00;
            tick();
        end
        check_val("t4_x_err", a_err_cnt, 0);
        a_en = 1'b1; a_gold = 8'h00; a_dut = {7'b0, zbit};
        tick();
        check_val("t5_z_mismatch", a_mismatch, 1);
        check_val("t5_z_err", a_err_cnt, 1);
        check_val("t5_z_first", a_first_err, 6);

        // reset at check 4 wins over en
        reset_a();
        for (int k = 0; k < 6; k++) begin
            a_en = 1'b1; a_gold = 8'(8'h10 + k);
            a_dut = (k >= 2) ? 8'(8'h10 + k - 2) : 8'h00;
            tick();
        end
        a_rst = 1'b1; a_en = 1'b1; a_gold = 8'h16; a_dut = 8'hFF;
        tick();
        a_rst = 1'b0;
        check_val("t6_valid", a_chk_valid, 0);
        check_val("t6_mismatch", a_mismatch, 0);
        check_val("t6_test", a_test, 0);
        check_val("t6_pat", a_pat, 0);
        check_val("t6_err", a_err_cnt, 0);
        check_val("t6_chk", a_chk_cnt, 0);
        check_val("t6_first", a_first_err, 16'hFFFF);
        check_val("t6_done", a_done, 0);
        for (int k = 0; k < 3; k++) begin
            a_en = 1'b1; a_gold = 8'(8'h30 + k);
            a_dut = (k >= 2) ? 8'h30 : 8'h00;
            tick();
            if (k == 1) check_val("t6_refill_valid", a_chk_valid, 0);
        end
        check_val("t6_restart_valid", a_chk_valid, 1);
        check_val("t6_restart_chk", a_chk_cnt, 1);
        check_val("t6_restart_pat", a_pat, 8'h30);
        check_val("t6_restart_err", a_err_cnt, 0);
        a_en = 1'b0;

        // zero latency, mismatch on the last sample
        for (int k = 0; k < 4; k++) begin
            z_en = 1'b1; z_gold = 8'(8'h40 + k);
            z_dut = (k == 3) ? 8'h00 : 8'(8'h40 + k);
            tick();
            if (k == 0) begin
                check_val("t7_first_valid", z_chk_valid, 1);
                check_val("t7_first_pat", z_pat, 8'h40);
                check_val("t7_first_chk", z_chk_cnt, 1);
            end
            if (k == 2) check_val("t7_done_early", z_done, 0);
        end
        check_val("t7_done", z_done, 1);
        check_val("t7_mismatch", z_mismatch, 1);
        check_val("t7_err", z_err_cnt, 1);
        check_val("t7_first", z_first_err, 3);
        check_val("t7_pass", z_pass, 0);
        z_en = 1'b1; z_gold = 8'h77; z_dut = 8'h00;
        tick();
        check_val("t7_post_valid", z_chk_valid, 0);
        check_val("t7_post_err", z_err_cnt, 1);
        check_val("t7_post_chk", z_chk_cnt, 4);
        check_val("t7_post_pat", z_pat, 8'h43);
        z_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
